// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encoding, fetch FSM states, reset PC.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_JR  = 2'b01;
   localparam logic [1:0] PC_BR  = 2'b10;
   localparam logic [1:0] PC_J   = 2'b11;

   localparam logic [1:0] ST_FETCH = 2'b00;
   localparam logic [1:0] ST_EXEC  = 2'b01;
   localparam logic [1:0] ST_ERROR = 2'b10;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ready handshake between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_ready;

   modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
   modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for sequential, jr, branch and jump flows.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_s,
   input  logic [XLEN-1:0] imm_data,
   input  logic [XLEN-1:0] jr_target,
   input  logic [25:0]     instr_index,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   logic [XLEN-1:0] seq_pc;

   always_comb begin
      seq_pc  = pc + 32'd4;
      next_pc = seq_pc;
      case (pc_s)
         PC_SEQ:  next_pc = seq_pc;
         PC_JR:   next_pc = jr_target;
         PC_BR:   next_pc = seq_pc + (imm_data << 2);
         PC_J:    next_pc = {seq_pc[31:28], instr_index, 2'b00};
         default: next_pc = seq_pc;
      endcase
      // Only jr can actually land here; the other sources are aligned by construction.
      misaligned = (next_pc[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction and holds it until retired.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned ADDR_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   fetch_unit_if.master        imem,
   input  logic                retire,
   input  logic [1:0]          pc_s,
   input  logic [XLEN-1:0]     imm_data,
   input  logic [XLEN-1:0]     jr_target,
   output logic [XLEN-1:0]     inst_code,
   output logic                inst_valid,
   output logic [XLEN-1:0]     pc,
   output logic [XLEN-1:0]     pc_plus4,
   output logic                misalign_err
);

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] code_next;
   logic            valid_next;
   logic            err_next;
   logic [XLEN-1:0] calc_pc;
   logic            calc_misaligned;

   next_pc_calc u_next_pc_calc (
      .pc          (pc),
      .pc_s        (pc_s),
      .imm_data    (imm_data),
      .jr_target   (jr_target),
      .instr_index (inst_code[25:0]),
      .next_pc     (calc_pc),
      .misaligned  (calc_misaligned)
   );

   // Request is gated by reset so it drops in the very cycle reset is asserted.
   assign imem.imem_req  = rst & (state == ST_FETCH);
   assign imem.imem_addr = pc[ADDR_W+1:2];
   assign pc_plus4       = pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_FETCH;
         pc           <= RESET_PC;
         inst_code    <= '0;
         inst_valid   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_next;
         pc           <= pc_next;
         inst_code    <= code_next;
         inst_valid   <= valid_next;
         misalign_err <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      code_next  = inst_code;
      valid_next = inst_valid;
      err_next   = misalign_err;
      case (state)
         ST_FETCH: begin
            if (imem.imem_ready) begin
               code_next  = imem.imem_rdata;
               valid_next = 1'b1;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (retire) begin
               valid_next = 1'b0;
               if (calc_misaligned) begin
                  err_next   = 1'b1;
                  state_next = ST_ERROR;
               end else begin
                  pc_next    = calc_pc;
                  state_next = ST_FETCH;
               end
            end
         end
         ST_ERROR: begin
            valid_next = 1'b0;
            err_next   = 1'b1;
         end
         default: state_next = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a wrap-around sequence.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        retire = 1'b0;
   logic [1:0]  pc_s = 2'b00;
   logic [31:0] imm_data = '0;
   logic [31:0] jr_target = '0;
   logic [31:0] inst_code, pc, pc_plus4;
   logic        inst_valid, misalign_err;

   logic        w_rst = 1'b0;
   logic        w_retire = 1'b0;
   logic [1:0]  w_pc_s = 2'b00;
   logic [31:0] w_inst_code, w_pc, w_pc_plus4;
   logic        w_inst_valid, w_misalign_err;

   int n_vec = 0;
   int n_fail = 0;

   fetch_unit_if #(.ADDR_W(6)) bus ();
   fetch_unit_if #(.ADDR_W(6)) wbus ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .imem(bus.master), .retire(retire), .pc_s(pc_s),
      .imm_data(imm_data), .jr_target(jr_target), .inst_code(inst_code),
      .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4), .misalign_err(misalign_err)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(6)) dut_wrap (
      .clk(clk), .rst(w_rst), .imem(wbus.master), .retire(w_retire), .pc_s(w_pc_s),
      .imm_data(32'h0), .jr_target(32'h0), .inst_code(w_inst_code),
      .inst_valid(w_inst_valid), .pc(w_pc), .pc_plus4(w_pc_plus4), .misalign_err(w_misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [31:0] rdata;
      logic        ret;
      logic [1:0]  pcs;
      logic [31:0] imm;
      logic [31:0] jr;
      bit          chk;
      logic        req;
      logic [5:0]  addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] code;
      logic        err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic rdy, input logic [31:0] rd, input logic ret,
                      input logic [1:0] pcs, input logic [31:0] imm, input logic [31:0] jr,
                      input bit chk, input logic req, input logic [5:0] addr, input logic valid,
                      input logic [31:0] epc, input logic [31:0] code, input logic err);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.rdata = rd; v.ret = ret; v.pcs = pcs; v.imm = imm; v.jr = jr;
      v.chk = chk; v.req = req; v.addr = addr; v.valid = valid; v.pc = epc; v.code = code;
      v.err = err;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      bus.imem_ready  = 1'b0;
      bus.imem_rdata  = '0;
      wbus.imem_ready = 1'b0;
      wbus.imem_rdata = '0;

      // Reset for two cycles, then sequential fetch with zero-wait memory
      add(0,1,32'h2001_0005,0,2'b00,0,0,           0, 0,6'd0, 0,32'h0,  32'h0,          0);
      add(0,1,32'h2001_0005,0,2'b00,0,0,           1, 0,6'd0, 0,32'h0,  32'h0,          0);
      add(1,1,32'h2001_0005,0,2'b00,0,0,           1, 1,6'd0, 0,32'h0,  32'h0,          0);
      add(1,0,32'h0,        1,2'b00,0,0,           1, 0,6'd0, 1,32'h0,  32'h2001_0005,  0);
      add(1,1,32'h2002_0007,0,2'b00,0,0,           1, 1,6'd1, 0,32'h4,  32'h2001_0005,  0);
      add(1,0,32'h0,        1,2'b00,0,0,           1, 0,6'd1, 1,32'h4,  32'h2002_0007,  0);
      // Three wait states at pc=8, junk data must not be captured
      add(1,0,32'hDEAD_BEEF,0,2'b00,0,0,           1, 1,6'd2, 0,32'h8,  32'h2002_0007,  0);
      add(1,0,32'hDEAD_BEEF,0,2'b00,0,0,           1, 1,6'd2, 0,32'h8,  32'h2002_0007,  0);
      add(1,0,32'hDEAD_BEEF,0,2'b00,0,0,           1, 1,6'd2, 0,32'h8,  32'h2002_0007,  0);
      add(1,1,32'hAC22_0004,0,2'b00,0,0,           1, 1,6'd2, 0,32'h8,  32'h2002_0007,  0);
      // Branch back by two words: 8+4-8 = 4
      add(1,0,32'h0,        1,2'b10,32'hFFFF_FFFE,0,1, 0,6'd2, 1,32'h8,  32'hAC22_0004,  0);
      add(1,1,32'h0800_0010,0,2'b00,0,0,           1, 1,6'd1, 0,32'h4,  32'hAC22_0004,  0);
      // Jump to index 0x10 -> 0x40
      add(1,0,32'h0,        1,2'b11,0,0,           1, 0,6'd1, 1,32'h4,  32'h0800_0010,  0);
      add(1,1,32'h0000_0020,0,2'b00,0,0,           1, 1,6'd16,0,32'h40, 32'h0800_0010,  0);
      add(1,0,32'h0,        1,2'b01,0,32'h30,      1, 0,6'd16,1,32'h40, 32'h0000_0020,  0);
      add(1,1,32'h1234_5678,0,2'b00,0,0,           1, 1,6'd12,0,32'h30, 32'h0000_0020,  0);
      // Misaligned jr goes to ERROR; retire afterwards is ignored
      add(1,0,32'h0,        1,2'b01,0,32'h32,      1, 0,6'd12,1,32'h30, 32'h1234_5678,  0);
      add(1,1,32'h0,        1,2'b00,0,0,           1, 0,6'd12,0,32'h30, 32'h1234_5678,  1);
      add(1,1,32'h0,        1,2'b00,0,0,           1, 0,6'd12,0,32'h30, 32'h1234_5678,  1);
      add(0,0,32'h0,        0,2'b00,0,0,           1, 0,6'd12,0,32'h30, 32'h1234_5678,  1);
      add(1,0,32'h0,        0,2'b00,0,0,           1, 1,6'd0, 0,32'h0,  32'h0,          0);
      add(1,0,32'h0,        0,2'b00,0,0,           1, 1,6'd0, 0,32'h0,  32'h0,          0);
      // Reset mid-handshake, then stray ready during EXEC
      add(0,0,32'h0,        0,2'b00,0,0,           1, 0,6'd0, 0,32'h0,  32'h0,          0);
      add(1,1,32'hAAAA_0001,0,2'b00,0,0,           1, 1,6'd0, 0,32'h0,  32'h0,          0);
      add(1,1,32'hBBBB_0002,0,2'b00,0,0,           1, 0,6'd0, 1,32'h0,  32'hAAAA_0001,  0);
      add(1,0,32'h0,        0,2'b00,0,0,           1, 0,6'd0, 1,32'h0,  32'hAAAA_0001,  0);
      // pc=0x100 aliases to word address 0
      add(1,0,32'h0,        1,2'b01,0,32'h100,     1, 0,6'd0, 1,32'h0,  32'hAAAA_0001,  0);
      add(1,0,32'h0,        0,2'b00,0,0,           1, 1,6'd0, 0,32'h100,32'hAAAA_0001,  0);
      add(1,1,32'h0000_0001,0,2'b00,0,0,           1, 1,6'd0, 0,32'h100,32'hAAAA_0001,  0);
      // Reset together with retire: reset wins
      add(0,0,32'h0,        1,2'b00,0,0,           1, 0,6'd0, 1,32'h100,32'h0000_0001,  0);
      add(1,0,32'h0,        0,2'b00,0,0,           1, 1,6'd0, 0,32'h0,  32'h0,          0);

      foreach (vq[i]) begin
         @(negedge clk);
         rst = vq[i].rst; bus.imem_ready = vq[i].rdy; bus.imem_rdata = vq[i].rdata;
         retire = vq[i].ret; pc_s = vq[i].pcs; imm_data = vq[i].imm; jr_target = vq[i].jr;
         #1;
         if (vq[i].chk) begin
            check($sformatf("v%0d.req", i),      32'(bus.imem_req),     32'(vq[i].req));
            check($sformatf("v%0d.addr", i),     32'(bus.imem_addr),    32'(vq[i].addr));
            check($sformatf("v%0d.valid", i),    32'(inst_valid),       32'(vq[i].valid));
            check($sformatf("v%0d.pc", i),       pc,                    vq[i].pc);
            check($sformatf("v%0d.pc_plus4", i), pc_plus4,              vq[i].pc + 32'd4);
            check($sformatf("v%0d.code", i),     inst_code,             vq[i].code);
            check($sformatf("v%0d.err", i),      32'(misalign_err),     32'(vq[i].err));
         end
      end

      // Wrap-around instance: RESET_PC at the top of the address space
      @(negedge clk); w_rst = 1'b0;
      @(negedge clk); w_rst = 1'b0;
      @(negedge clk); w_rst = 1'b1;
      #1;
      begin
         int cyc = 0;
         while (!wbus.imem_req && cyc < 8) begin
            @(negedge clk); #1; cyc++;
         end
         check("wrap.req_seen", 32'(wbus.imem_req), 32'd1);
      end
      check("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
      check("wrap.addr_top", 32'(wbus.imem_addr), 32'h3F);
      check("wrap.pc_plus4", w_pc_plus4, 32'h0);
      wbus.imem_ready = 1'b1; wbus.imem_rdata = 32'h0000_00AA;
      @(negedge clk);
      wbus.imem_ready = 1'b0; w_retire = 1'b1; w_pc_s = 2'b00;
      #1;
      check("wrap.valid", 32'(w_inst_valid), 32'd1);
      check("wrap.code", w_inst_code, 32'h0000_00AA);
      @(negedge clk);
      w_retire = 1'b0;
      #1;
      check("wrap.pc_zero", w_pc, 32'h0);
      check("wrap.addr_zero", 32'(wbus.imem_addr), 32'h0);
      check("wrap.refetch", 32'(wbus.imem_req), 32'd1);
      check("wrap.err", 32'(w_misalign_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle decode/regfile/ALU datapath.
- Owns the PC and requests words from a word-addressed instruction memory using a req/ready handshake.
- Holds the fetched instruction stable until the execute side retires it, then computes the next PC.
- Next-PC sources: sequential, branch, jump, or register jump (jr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 6, instruction-memory word-address width; memory depth is 2^ADDR_W words.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on the clk rising edge).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  word address, equal to pc[ADDR_W+1:2].
- imem_rdata  in  32  instruction word from memory; valid in the cycle imem_ready=1.
- imem_ready  in  1  memory has completed the request; rdata is valid.
- retire  in  1  execute side has consumed inst_code this cycle.
- pc_s  in  2  next-PC select, sampled with retire: 00 pc+4; 01 jr_target; 10 branch; 11 jump.
- imm_data  in  32  sign-extended branch offset, in words.
- jr_target  in  32  register jump target (rs value).
- inst_code  out  32  current instruction, held stable while inst_valid=1.
- inst_valid  out  1  inst_code is valid for decode.
- pc  out  32  address of inst_code.
- pc_plus4  out  32  pc+4, used as the link value for jal.
- misalign_err  out  1  sticky flag: a jr target was not word-aligned.

Behaviour:
- Reset (rst=0 at a clk edge):
  - pc=RESET_PC, state=FETCH, inst_code=0, inst_valid=0, misalign_err=0.
  - imem_req is 0 during any cycle in which rst=0.
  - A reset in any state, including mid-handshake, aborts the current fetch.
  - Any late imem_ready after the reset is ignored unless the unit is back in FETCH.
- State FETCH:
  - imem_req=1; imem_addr held constant.
  - When imem_ready=1: inst_code<=imem_rdata, inst_valid<=1, next state EXEC.
  - If imem_ready=0, stay in FETCH indefinitely; no timeout.
- State EXEC:
  - inst_valid=1, imem_req=0; inst_code and pc are frozen.
  - On retire=1, latch pc<=next_pc, inst_valid<=0, and go to FETCH.
  - If next_pc[1:0]!=00, go to ERROR instead and leave pc unchanged.
- State ERROR:
  - misalign_err=1, inst_valid=0, imem_req=0.
  - Only reset exits this state.
- retire is ignored in FETCH and ERROR.
- imem_ready is ignored outside FETCH.
- next_pc computation:
  - 00: pc+4.
  - 01: jr_target.
  - 10: pc+4 + (imm_data<<2).
  - 11: {pc_plus4[31:28], inst_code[25:0], 2'b00}.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Misalignment: only source 01 can produce a misaligned target, because the other sources are aligned by construction.
- imem_addr wraps modulo 2^ADDR_W, since the upper pc bits are not decoded.
- pc_plus4 is combinational from pc.
- Latency:
  - With a zero-wait memory (imem_ready=1 in the same cycle as req), inst_valid rises 1 cycle after entering FETCH.
  - Throughput is at best one instruction per 2 cycles.
  - Each memory wait cycle adds 1 cycle.
- Simultaneous rst=0 and retire=1: reset wins.

Decomposition:
- Shared package (cpu_pkg) holds:
  - PC_SEQ=2'b00, PC_JR=2'b01, PC_BR=2'b10, PC_J=2'b11; the decoder uses the same encoding.
  - The FSM state encoding: FETCH, EXEC, ERROR.
  - The RESET_PC default.
- One natural sub-module: next_pc_calc. It is purely combinational: pc, pc_s, imm_data, jr_target, and instr_index in; next_pc and misaligned out.

Test Plan:
1. Reset and sequential fetch: hold rst=0 for 2 cycles with zero-wait memory returning 32'h2001_0005 at addr 0, then retire every EXEC cycle. Required: pc goes 0,4,8; imem_addr goes 0,1,2; inst_valid high every other cycle; pc_plus4 = pc+4.
2. Wait states: imem_ready held low 3 cycles, then high with 32'hAC22_0004. Required: imem_req stays 1 with a stable addr for 4 cycles; inst_code is captured only on the ready cycle; inst_valid rises the next cycle.
3. Branch and jump: at pc=8, retire with pc_s=10 and imm_data=32'hFFFF_FFFE; required pc=4. With inst_code=32'h0800_0010 and pc_s=11 at pc=4; required pc=32'h0000_0040.
4. Register jump and error: retire with pc_s=01 and jr_target=32'h0000_0030; required pc=32'h30. Then jr_target=32'h0000_0032; required ERROR state, misalign_err=1, imem_req=0, pc still 32'h30, and retire ignored.
5. Reset mid-operation: assert rst=0 while in FETCH with imem_ready=0, then release. Required: pc=RESET_PC, misalign_err cleared, and a fresh request at addr 0. A stray imem_ready pulse during EXEC does not change inst_code.
6. Wrap-around: set RESET_PC=32'hFFFF_FFFC and retire with pc_s=00. Required: pc=0. With ADDR_W=6 and pc=32'h100, required imem_addr=0.
